// File: rtl/l1_mshr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : l1_mshr_pkg
// Description : Shared types for the L1 miss-status holding register file.
// Revision    : 1.0 - initial release
// ============================================================================
package l1_mshr_pkg;

    localparam int c_DEF_LINE_BITS    = 5;
    localparam int c_DEF_DATA_WIDTH   = 32;
    localparam int c_DEF_CREG_ID_BITS = 4;

    typedef enum logic [1:0] {
        FREE = 2'd0,
        PEND = 2'd1,
        WAIT = 2'd2,
        FILL = 2'd3
    } entry_state_e;

    typedef enum logic [0:0] {
        R_IDLE   = 1'b0,
        R_REPLAY = 1'b1
    } replay_state_e;

    // Default-width target record; the top re-declares it at its own widths.
    typedef struct packed {
        logic [c_DEF_LINE_BITS-1:0]    offset;
        logic                          rw;
        logic [c_DEF_DATA_WIDTH-1:0]   data;
        logic [c_DEF_CREG_ID_BITS-1:0] id;
    } mshr_target_t;

endpackage
`default_nettype wire

// File: rtl/l1_mshr_target_list.sv
`default_nettype none
// ============================================================================
// Module      : l1_mshr_target_list
// Description : Append-only list of merged requests for one MSHR entry.
// Revision    : 1.0 - initial release
// ============================================================================
module l1_mshr_target_list
    import l1_mshr_pkg::*;
#(
    parameter int  TARGETS  = 4,
    parameter type target_t = mshr_target_t
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    push,
    input  target_t push_data,
    input  logic    pop,
    input  logic    clear,
    output target_t head,
    output logic    first,
    output logic    last,
    output logic    full
);
    localparam int c_CNT_W = $clog2(TARGETS + 1);
    localparam int c_PTR_W = (TARGETS > 1) ? $clog2(TARGETS) : 1;

    target_t              r_mem [TARGETS];
    logic [c_CNT_W-1:0]   r_count;
    logic [c_PTR_W-1:0]   r_ptr;

    assign head  = r_mem[r_ptr];
    assign first = (r_ptr == '0);
    assign last  = ((c_CNT_W'(r_ptr) + c_CNT_W'(1)) == r_count);
    assign full  = (r_count == c_CNT_W'(TARGETS));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_count <= '0;
            r_ptr   <= '0;
        end else begin
            if (push && !full) begin
                r_count <= r_count + 1'b1;
            end
            if (pop) begin
                r_ptr <= r_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            r_mem[r_count[c_PTR_W-1:0]] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/l1_mshr_file.sv
`default_nettype none
// ============================================================================
// Module      : l1_mshr_file
// Description : Non-blocking L1D MSHR file: merge, L2 issue, in-order replay.
// Revision    : 1.0 - initial release
// ============================================================================
module l1_mshr_file
    import l1_mshr_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int LINE_BITS    = 5,
    parameter int DATA_WIDTH   = 32,
    parameter int WORDS        = 8,
    parameter int CREG_ID_BITS = 4,
    parameter int ENTRIES      = 4,
    parameter int MSHR_ID_BITS = 2,
    parameter int TARGETS      = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        miss_valid,
    input  logic [ADDR_WIDTH-1:0]       miss_addr,
    input  logic                        miss_rw,
    input  logic [DATA_WIDTH-1:0]       miss_data,
    input  logic [CREG_ID_BITS-1:0]     miss_id,
    output logic                        miss_ready,
    output logic                        l2_req_valid,
    output logic [ADDR_WIDTH-1:0]       l2_req_addr,
    output logic [MSHR_ID_BITS-1:0]     l2_req_id,
    input  logic                        l2_req_ready,
    input  logic                        l2_resp_valid,
    input  logic [MSHR_ID_BITS-1:0]     l2_resp_id,
    input  logic [DATA_WIDTH*WORDS-1:0] l2_resp_data,
    output logic                        l2_resp_ready,
    output logic                        rep_valid,
    output logic [ADDR_WIDTH-1:0]       rep_addr,
    output logic                        rep_rw,
    output logic [DATA_WIDTH-1:0]       rep_data,
    output logic [CREG_ID_BITS-1:0]     rep_id,
    output logic [DATA_WIDTH*WORDS-1:0] rep_line,
    output logic                        rep_first,
    output logic                        rep_last,
    input  logic                        rep_ready,
    output logic                        full,
    output logic                        empty,
    output logic                        resp_err
);
    localparam int c_TAG_W  = ADDR_WIDTH - LINE_BITS;
    localparam int c_LINE_W = DATA_WIDTH * WORDS;

    typedef struct packed {
        logic [LINE_BITS-1:0]    offset;
        logic                    rw;
        logic [DATA_WIDTH-1:0]   data;
        logic [CREG_ID_BITS-1:0] id;
    } tgt_rec_t;

    entry_state_e              r_state     [ENTRIES];
    entry_state_e              w_state_nxt [ENTRIES];
    logic [c_TAG_W-1:0]        r_line      [ENTRIES];
    tgt_rec_t                  w_head      [ENTRIES];
    replay_state_e             r_rstate, w_rstate_nxt;
    logic [MSHR_ID_BITS-1:0]   r_rep_idx;
    logic [c_LINE_W-1:0]       r_fill_line;
    logic                      r_req_valid;
    logic [ADDR_WIDTH-1:0]     r_req_addr;
    logic [MSHR_ID_BITS-1:0]   r_req_id;
    logic                      r_full, r_empty, r_resp_err;

    logic [c_TAG_W-1:0]        w_miss_line, w_sel_line;
    logic [ENTRIES-1:0]        w_match, w_push, w_pop, w_clear, w_tfull, w_first, w_last;
    tgt_rec_t                  w_new_tgt;
    logic                      w_hit, w_accept, w_alloc, w_sel_valid;
    logic [MSHR_ID_BITS-1:0]   w_hit_idx, w_free_idx, w_tgt_idx, w_sel_idx;
    logic                      w_req_hs, w_resp_acc, w_resp_ok, w_rep_fire, w_rep_done;
    logic                      w_full_nxt, w_empty_nxt;

    assign w_miss_line = miss_addr[ADDR_WIDTH-1:LINE_BITS];
    assign w_new_tgt   = '{offset: miss_addr[LINE_BITS-1:0], rw: miss_rw,
                           data: miss_data, id: miss_id};

    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
        assign w_match[gi] = (r_state[gi] != FREE) && (r_line[gi] == w_miss_line);
        assign w_push[gi]  = w_accept   && (w_tgt_idx == MSHR_ID_BITS'(gi));
        assign w_pop[gi]   = w_rep_fire && (r_rep_idx == MSHR_ID_BITS'(gi));
        assign w_clear[gi] = w_rep_done && (r_rep_idx == MSHR_ID_BITS'(gi));

        l1_mshr_target_list #(
            .TARGETS  (TARGETS),
            .target_t (tgt_rec_t)
        ) u_tlist (
            .clk       (clk),
            .reset     (reset),
            .push      (w_push[gi]),
            .push_data (w_new_tgt),
            .pop       (w_pop[gi]),
            .clear     (w_clear[gi]),
            .head      (w_head[gi]),
            .first     (w_first[gi]),
            .last      (w_last[gi]),
            .full      (w_tfull[gi])
        );
    end

    // At most one entry can match a line, so the encoder only needs priority for FREE.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_idx  = '0;
        w_free_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                w_hit     = 1'b1;
                w_hit_idx = MSHR_ID_BITS'(i);
            end
            if (r_state[i] == FREE) begin
                w_free_idx = MSHR_ID_BITS'(i);
            end
        end
    end

    always_comb begin
        if (w_hit) begin
            miss_ready = ((r_state[w_hit_idx] == PEND) || (r_state[w_hit_idx] == WAIT))
                         && !w_tfull[w_hit_idx];
        end else begin
            miss_ready = !r_full;
        end
    end

    assign w_accept   = miss_valid && miss_ready;
    assign w_alloc    = w_accept && !w_hit;
    assign w_tgt_idx  = w_hit ? w_hit_idx : w_free_idx;
    assign w_req_hs   = r_req_valid && l2_req_ready;
    assign w_resp_acc = l2_resp_valid && l2_resp_ready;
    assign w_resp_ok  = w_resp_acc && (r_state[l2_resp_id] == WAIT);
    assign w_rep_fire = rep_valid && rep_ready;
    assign w_rep_done = w_rep_fire && w_last[r_rep_idx];

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            w_state_nxt[i] = r_state[i];
            case (r_state[i])
                FREE: if (w_alloc && (w_free_idx == MSHR_ID_BITS'(i)))     w_state_nxt[i] = PEND;
                PEND: if (w_req_hs && (r_req_id == MSHR_ID_BITS'(i)))      w_state_nxt[i] = WAIT;
                WAIT: if (w_resp_ok && (l2_resp_id == MSHR_ID_BITS'(i)))   w_state_nxt[i] = FILL;
                FILL: if (w_rep_done && (r_rep_idx == MSHR_ID_BITS'(i)))   w_state_nxt[i] = FREE;
                default: w_state_nxt[i] = r_state[i];
            endcase
        end
    end

    // Selecting from next-state lets a fresh allocation issue one cycle later
    // and drops the entry whose request is handshaking now.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_idx   = '0;
        w_sel_line  = '0;
        w_full_nxt  = 1'b1;
        w_empty_nxt = 1'b1;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (w_state_nxt[i] == PEND) begin
                w_sel_valid = 1'b1;
                w_sel_idx   = MSHR_ID_BITS'(i);
                w_sel_line  = (w_alloc && (w_free_idx == MSHR_ID_BITS'(i))) ? w_miss_line
                                                                             : r_line[i];
            end
            if (w_state_nxt[i] == FREE) begin
                w_full_nxt = 1'b0;
            end else begin
                w_empty_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_state[i] <= FREE;
            end
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_req_valid <= 1'b0;
            r_req_addr  <= '0;
            r_req_id    <= '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_state[i] <= w_state_nxt[i];
            end
            r_full  <= w_full_nxt;
            r_empty <= w_empty_nxt;
            if (!r_req_valid || l2_req_ready) begin
                r_req_valid <= w_sel_valid;
                r_req_id    <= w_sel_idx;
                r_req_addr  <= {w_sel_line, {LINE_BITS{1'b0}}};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_alloc) begin
            r_line[w_free_idx] <= w_miss_line;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rep_idx   <= '0;
            r_fill_line <= '0;
            r_resp_err  <= 1'b0;
        end else begin
            if (w_resp_ok) begin
                r_rep_idx   <= l2_resp_id;
                r_fill_line <= l2_resp_data;
            end
            if (w_resp_acc && !w_resp_ok) begin
                r_resp_err <= 1'b1;
            end
        end
    end

    // Replay FSM: state register / next-state / outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rstate <= R_IDLE;
        end else begin
            r_rstate <= w_rstate_nxt;
        end
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE:   if (w_resp_ok)  w_rstate_nxt = R_REPLAY;
            R_REPLAY: if (w_rep_done) w_rstate_nxt = R_IDLE;
            default:  w_rstate_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        l2_resp_ready = 1'b0;
        rep_valid     = 1'b0;
        rep_addr      = '0;
        rep_rw        = 1'b0;
        rep_data      = '0;
        rep_id        = '0;
        rep_line      = '0;
        rep_first     = 1'b0;
        rep_last      = 1'b0;
        case (r_rstate)
            R_IDLE: l2_resp_ready = 1'b1;
            R_REPLAY: begin
                rep_valid = 1'b1;
                rep_addr  = {r_line[r_rep_idx], w_head[r_rep_idx].offset};
                rep_rw    = w_head[r_rep_idx].rw;
                rep_data  = w_head[r_rep_idx].data;
                rep_id    = w_head[r_rep_idx].id;
                rep_line  = r_fill_line;
                rep_first = w_first[r_rep_idx];
                rep_last  = w_last[r_rep_idx];
            end
            default: ;
        endcase
    end

    assign l2_req_valid = r_req_valid;
    assign l2_req_addr  = r_req_addr;
    assign l2_req_id    = r_req_id;
    assign full         = r_full;
    assign empty        = r_empty;
    assign resp_err     = r_resp_err;

endmodule
`default_nettype wire
